multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS-subset datapath. It sits beside the ALU controller and drives PC/IR write enables, memory handshakes, mux selects and the 3-bit ALUOp code. Each instruction runs as a sequence of states. Multiply (R-type funct 24) is held in EX for a parameterised number of cycles. Memory accesses stall until the memory acknowledges.

## Interface
- MUL_CYCLES, 4: total EX cycles for mul, range 1..16
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- opcode_i  in  6  IR[31:26], stable after fetch
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory acknowledge for the current read/write
- pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o  out  1 each  enables
- iord_o  out  1  memory address select: 0=PC, 1=ALUOut
- mem_to_reg_o  out  1  write-back data select: 1=MDR
- reg_dst_o  out  1  destination select: 1=rd, 0=rt
- alu_src_a_o  out  1  ALU A select: 0=PC, 1=rs
- alu_src_b_o  out  2  ALU B select: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp_o  out  3  0=R-type, 1=beq, 2=bne, 3=add, 4=sltiu, 5=ori, 6=lui
- pc_source_o  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=rs
- illegal_o  out  1  one-cycle pulse on unsupported opcode
- state_o  out  4  current state, for debug

## Operation
- State encodings: IDLE0, FETCH1, DECODE2, EXEC_R3, MUL_WAIT4, R_WB5, EXEC_I6, I_WB7, ADDR8, MEM_RD9, MEM_WB10, MEM_WR11, BRANCH12, JUMP13, JR14. Codes 15 and above are unused; any unused code goes to IDLE.
- All outputs are combinational from state plus the listed inputs. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=1, ALUOp=3, pc_source=0.
  - If mem_ready_i=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: src_a=0, src_b=3, ALUOp=3 (computes the branch target). Next state by opcode:
  - 0 with funct 8 → JR; 0 with any other funct → EXEC_R
  - 2 → JUMP
  - 4, 5 → BRANCH
  - 8, 11, 13, 15 → EXEC_I
  - 35, 43 → ADDR
  - any other opcode: illegal_o=1 and go to FETCH.
- EXEC_R: src_a=1, src_b=0, ALUOp=0.
  - funct 24 and MUL_CYCLES>1 → MUL_WAIT, with the counter loaded to MUL_CYCLES-2.
  - Otherwise → R_WB.
- MUL_WAIT: same outputs as EXEC_R. Counter decrements each cycle; leave for R_WB in the cycle the counter reads 0. Mul therefore spends exactly MUL_CYCLES cycles in EXEC_R plus MUL_WAIT.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- EXEC_I: src_a=1, src_b=2. ALUOp by opcode: 8→3, 11→4, 13→5, 15→6. Next state I_WB.
- I_WB: reg_dst=0, reg_write=1. Next state FETCH.
- ADDR: src_a=1, src_b=2, ALUOp=3. Opcode 35 → MEM_RD; opcode 43 → MEM_WR.
- MEM_RD: iord=1, mem_read=1. Hold until mem_ready_i=1, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEM_WR: iord=1, mem_write=1. Hold until mem_ready_i=1, then go to FETCH.
- BRANCH: src_a=1, src_b=0, pc_source=1, pc_write=zero_i. ALUOp=1 for opcode 4, 2 for opcode 5; the ALU's bne operation raises zero when the operands differ. Next state FETCH.
- JUMP: pc_source=2, pc_write=1. Next state FETCH.
- JR: pc_source=3, pc_write=1. Next state FETCH.

## Timing
- rst_i low: state forced to IDLE and counter to 0 immediately, asynchronously, including mid-mul or mid-stall. All outputs read 0 while in reset.
- First rising edge after rst_i rises: IDLE→FETCH.
- Cycle counts with zero-wait memory (FETCH through the last state):
  - R-type: 4
  - mul: 3+MUL_CYCLES
  - I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j/jr: 3
- Each cycle of mem_ready_i=0 during FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_read_o and mem_write_o are never both 1.
- pc_write_o and ir_write_o are asserted only in the acknowledged FETCH cycle, plus pc_write_o in BRANCH, JUMP and JR.

## Test plan
- Reset, release, opcode 0 / funct 32, mem_ready_i=1 → state_o 0,1,2,3,5,1; reg_write_o=1 and reg_dst_o=1 only in state 5.
- Mul (funct 24), MUL_CYCLES=4 → state_o sequence 1,2,3,4,4,4,5; ALUOp_o=0 throughout states 3 and 4.
- lw (35) with mem_ready_i low for 2 cycles in MEM_RD → 1,2,8,9,9,9,10,1; iord_o=1 in all three MEM_RD cycles.
- beq (4) with zero_i=1 → pc_write_o=1, pc_source_o=1 in BRANCH. bne (5) with zero_i=0 → pc_write_o=0 and ALUOp_o=2.
- opcode 63 → illegal_o pulses in DECODE only; next state FETCH; no register or memory write occurs.
- rst_i pulled low during the second MUL_WAIT cycle → state_o=0 and all outputs 0 immediately. After release, the next instruction fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset datapath: sequences each
// instruction through fetch/decode/execute states and drives datapath controls.
module multicycle_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       iord_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] ALUOp_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_MUL_WAIT = 4'd4,
    S_R_WB     = 4'd5,
    S_EXEC_I   = 4'd6,
    S_I_WB     = 4'd7,
    S_ADDR     = 4'd8,
    S_MEM_RD   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_BRANCH   = 4'd12,
    S_JUMP     = 4'd13,
    S_JR       = 4'd14
  } state_t;

  // EXEC_R accounts for one mul cycle and the zero-count cycle for another.
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cntNext;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cntNext    = r_cnt;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    iord_o       = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    ALUOp_o      = 3'd0;
    pc_source_o  = 2'd0;
    illegal_o    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        ALUOp_o     = 3'd3;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
        ALUOp_o     = 3'd3;
        case (opcode_i)
          6'd0:                       w_next = (funct_i == 6'd8) ? S_JR : S_EXEC_R;
          6'd2:                       w_next = S_JUMP;
          6'd4, 6'd5:                 w_next = S_BRANCH;
          6'd8, 6'd11, 6'd13, 6'd15:  w_next = S_EXEC_I;
          6'd35, 6'd43:               w_next = S_ADDR;
          default: begin
            illegal_o = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        if ((funct_i == 6'd24) && (MUL_CYCLES > 1)) begin
          w_next    = S_MUL_WAIT;
          w_cntNext = MUL_LOAD;
        end else begin
          w_next = S_R_WB;
        end
      end
      S_MUL_WAIT: begin
        alu_src_a_o = 1'b1;
        if (r_cnt == 4'd0) w_next = S_R_WB;
        else               w_cntNext = r_cnt - 4'd1;
      end
      S_R_WB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        case (opcode_i)
          6'd11:   ALUOp_o = 3'd4;
          6'd13:   ALUOp_o = 3'd5;
          6'd15:   ALUOp_o = 3'd6;
          default: ALUOp_o = 3'd3;
        endcase
        w_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        ALUOp_o     = 3'd3;
        case (opcode_i)
          6'd35:   w_next = S_MEM_RD;
          6'd43:   w_next = S_MEM_WR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ready_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) w_next = S_FETCH;
      end
      // The ALU's bne op raises zero on inequality, so pc_write follows zero either way.
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        pc_source_o = 2'd1;
        pc_write_o  = zero_i;
        ALUOp_o     = (opcode_i == 6'd5) ? 3'd2 : 3'd1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_source_o = 2'd2;
        pc_write_o  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JR: begin
        pc_source_o = 2'd3;
        pc_write_o  = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected states are queued
// per instruction, then popped and compared against the DUT each cycle.
module tb_multicycle_ctrl;

  localparam int MUL = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o;
  logic       iord_o, mem_to_reg_o, reg_dst_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] ALUOp_o;
  logic [3:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] st;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       ready;
  } step_t;

  step_t scoreQ[$];

  multicycle_ctrl #(.MUL_CYCLES(MUL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .iord_o(iord_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .ALUOp_o(ALUOp_o), .pc_source_o(pc_source_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Output bundle order: pcw irw mrd mwr rgw iord m2r rdst srcA srcB[2] aluop[3] pcsrc[2] ill
  function automatic logic [31:0] packOuts(
      input logic pcw, irw, mrd, mwr, rgw, iord, m2r, rdst, srca,
      input logic [1:0] srcb, input logic [2:0] aluop, input logic [1:0] pcsrc,
      input logic ill);
    return {15'd0, pcw, irw, mrd, mwr, rgw, iord, m2r, rdst, srca, srcb, aluop, pcsrc, ill};
  endfunction

  function automatic logic [31:0] dutOuts();
    return packOuts(pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
                    iord_o, mem_to_reg_o, reg_dst_o, alu_src_a_o, alu_src_b_o,
                    ALUOp_o, pc_source_o, illegal_o);
  endfunction

  // Expected control outputs for a state, written from the state output table.
  function automatic logic [31:0] expOuts(input step_t s);
    logic legal;
    legal = (s.op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd11, 6'd13, 6'd15, 6'd35, 6'd43});
    case (s.st)
      4'd1:  return packOuts(s.ready, s.ready, 1, 0, 0, 0, 0, 0, 0, 2'd1, 3'd3, 2'd0, 0);
      4'd2:  return packOuts(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'd3, 2'd0, !legal);
      4'd3,
      4'd4:  return packOuts(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 0);
      4'd5:  return packOuts(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0, 3'd0, 2'd0, 0);
      4'd6:  return packOuts(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2,
                             (s.op == 6'd11) ? 3'd4 : (s.op == 6'd13) ? 3'd5 :
                             (s.op == 6'd15) ? 3'd6 : 3'd3, 2'd0, 0);
      4'd7:  return packOuts(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0);
      4'd8:  return packOuts(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd3, 2'd0, 0);
      4'd9:  return packOuts(0, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0);
      4'd10: return packOuts(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd0, 3'd0, 2'd0, 0);
      4'd11: return packOuts(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 0);
      4'd12: return packOuts(s.zero, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0,
                             (s.op == 6'd5) ? 3'd2 : 3'd1, 2'd1, 0);
      4'd13: return packOuts(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2, 0);
      4'd14: return packOuts(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd3, 0);
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushStep(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                          input logic zero, input logic ready);
    step_t s;
    s.st = st; s.op = op; s.fn = fn; s.zero = zero; s.ready = ready;
    scoreQ.push_back(s);
  endtask

  // Queue the expected per-cycle state sequence for one instruction.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input int fetchWait, input int memWait);
    for (int i = 0; i < fetchWait; i++) pushStep(4'd1, op, fn, zero, 1'b0);
    pushStep(4'd1, op, fn, zero, 1'b1);
    pushStep(4'd2, op, fn, zero, 1'b1);
    case (op)
      6'd0: begin
        if (fn == 6'd8) pushStep(4'd14, op, fn, zero, 1'b1);
        else begin
          pushStep(4'd3, op, fn, zero, 1'b1);
          if (fn == 6'd24)
            for (int i = 1; i < MUL; i++) pushStep(4'd4, op, fn, zero, 1'b1);
          pushStep(4'd5, op, fn, zero, 1'b1);
        end
      end
      6'd2:       pushStep(4'd13, op, fn, zero, 1'b1);
      6'd4, 6'd5: pushStep(4'd12, op, fn, zero, 1'b1);
      6'd8, 6'd11, 6'd13, 6'd15: begin
        pushStep(4'd6, op, fn, zero, 1'b1);
        pushStep(4'd7, op, fn, zero, 1'b1);
      end
      6'd35: begin
        pushStep(4'd8, op, fn, zero, 1'b1);
        for (int i = 0; i < memWait; i++) pushStep(4'd9, op, fn, zero, 1'b0);
        pushStep(4'd9, op, fn, zero, 1'b1);
        pushStep(4'd10, op, fn, zero, 1'b1);
      end
      6'd43: begin
        pushStep(4'd8, op, fn, zero, 1'b1);
        for (int i = 0; i < memWait; i++) pushStep(4'd11, op, fn, zero, 1'b0);
        pushStep(4'd11, op, fn, zero, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic runQueue();
    step_t s;
    while (scoreQ.size() > 0) begin
      s = scoreQ.pop_front();
      @(negedge clk_i);
      opcode_i    = s.op;
      funct_i     = s.fn;
      zero_i      = s.zero;
      mem_ready_i = s.ready;
      #1;
      checkOutput($sformatf("state op%0d", s.op), {28'd0, state_o}, {28'd0, s.st});
      checkOutput($sformatf("outs op%0d st%0d", s.op, s.st), dutOuts(), expOuts(s));
      checkOutput("rd_wr_exclusive", {31'd0, mem_read_o & mem_write_o}, 32'd0);
    end
  endtask

  initial begin
    rst_i = 1'b0; opcode_i = 6'd0; funct_i = 6'd32; zero_i = 1'b0; mem_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("reset state", {28'd0, state_o}, 32'd0);
    checkOutput("reset outs", dutOuts(), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("idle after release", {28'd0, state_o}, 32'd0);

    applyStimulus(6'd0,  6'd32, 1'b0, 0, 0);
    applyStimulus(6'd0,  6'd24, 1'b0, 0, 0);
    applyStimulus(6'd35, 6'd0,  1'b0, 0, 2);
    applyStimulus(6'd4,  6'd0,  1'b1, 0, 0);
    applyStimulus(6'd5,  6'd0,  1'b0, 0, 0);
    applyStimulus(6'd63, 6'd0,  1'b0, 0, 0);
    applyStimulus(6'd43, 6'd0,  1'b0, 1, 1);
    applyStimulus(6'd8,  6'd0,  1'b0, 0, 0);
    applyStimulus(6'd11, 6'd0,  1'b0, 0, 0);
    applyStimulus(6'd13, 6'd0,  1'b0, 2, 0);
    applyStimulus(6'd15, 6'd0,  1'b0, 0, 0);
    applyStimulus(6'd2,  6'd0,  1'b0, 0, 0);
    applyStimulus(6'd0,  6'd8,  1'b0, 0, 0);
    applyStimulus(6'd4,  6'd0,  1'b0, 0, 0);
    applyStimulus(6'd5,  6'd0,  1'b1, 0, 0);
    applyStimulus(6'd35, 6'd0,  1'b0, 0, 0);
    runQueue();

    // Asynchronous reset in the second MUL_WAIT cycle
    pushStep(4'd1, 6'd0, 6'd24, 1'b0, 1'b1);
    pushStep(4'd2, 6'd0, 6'd24, 1'b0, 1'b1);
    pushStep(4'd3, 6'd0, 6'd24, 1'b0, 1'b1);
    pushStep(4'd4, 6'd0, 6'd24, 1'b0, 1'b1);
    runQueue();
    @(negedge clk_i);
    #1;
    checkOutput("second mul_wait", {28'd0, state_o}, 32'd4);
    rst_i = 1'b0;
    #1;
    checkOutput("async reset state", {28'd0, state_o}, 32'd0);
    checkOutput("async reset outs", dutOuts(), 32'd0);
    @(negedge clk_i);
    #1;
    checkOutput("held reset state", {28'd0, state_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("idle after re-release", {28'd0, state_o}, 32'd0);
    applyStimulus(6'd0, 6'd32, 1'b0, 0, 0);
    applyStimulus(6'd0, 6'd24, 1'b0, 0, 0);
    runQueue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
